isqrt_pipe: RTL and testbench
=============================

# isqrt_pipe

Fully pipelined integer square root: y = floor(sqrt(x)) for an unsigned WIDTH-bit operand. The block computes one result bit per stage, accepts a new operand every cycle and returns results in order after a fixed latency. It is the sqrt building block that feeds the formula pipelines: three copies run side by side, their y outputs go into the summing stage, and that stage uses one copy's y_vld as its qualifier. Data registers are clocked only for valid tokens, which saves dynamic power.

## Interface
- WIDTH, 32: operand width. Must be even and ≥ 2. Result width is WIDTH/2.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- x_vld  in  1  operand valid. There is no ready signal; the block accepts x_vld every cycle.
- x  in  WIDTH  unsigned operand, sampled when x_vld=1.
- y_vld  out  1  result valid. Reset value 0.
- y  out  WIDTH/2  floor(sqrt(x)). Not reset. Meaningful only when y_vld=1.

## Operation
- Algorithm: digit-by-digit restoring method, two operand bits per stage, MSB pair first. There are N = WIDTH/2 stages.
- Per-stage state:
  - v: valid bit.
  - xs: operand bits not yet consumed, left-aligned, WIDTH bits.
  - rem: partial remainder, N+2 bits.
  - root: partial root, N bits.
- Stage step:
  - rem' = (rem << 2) | xs[WIDTH-1:WIDTH-2]
  - trial = (root << 2) | 1, N+2 bits
  - If rem' ≥ trial (unsigned): rem ← rem' − trial and root ← (root << 1) | 1.
  - Otherwise: rem ← rem' and root ← root << 1.
  - xs ← xs << 2.
- Stage 0 inputs are rem=0, root=0, xs=x.
- Width rules: rem never exceeds 2·root+1, so N+2 bits cannot overflow. All compares and subtracts are unsigned, with no truncation until y = the root of the last stage.
- Valid chain: v of stage k ← v of stage k−1, with x_vld feeding stage 0. These bits are the only flops that reset, and they reset to 0.
- Power gating: the xs/rem/root registers of a stage load only when that stage's incoming valid is 1. Otherwise they hold. No reset is applied to data flops.
- The final stage does not need xs or rem; unused flops may be pruned.

## Timing
- Latency is exactly N cycles: x_vld/x sampled at edge t produce y_vld=1 and y during the cycle after edge t+N−1. For WIDTH=32, N=16.
- Throughput is 1 per cycle. Back-to-back operands produce back-to-back results. Bubbles in x_vld reappear unchanged N cycles later.
- y holds its last valid value while y_vld=0. Bench checks y only when y_vld=1.
- Reset assertion clears every valid bit immediately (async); operands in flight are discarded and no y_vld pulse appears for them.
- After reset deassertion the pipeline is empty; the first y_vld comes N cycles after the first accepted x_vld.
- x_vld during reset is ignored.

## Structure
- Package isqrt_pkg holds:
  - function isqrt_latency(width), which returns width/2, for consumers that align side-band data;
  - a localparam check (WIDTH even) used by an elaboration-time assertion.
- Sub-module isqrt_stage implements one step, combinationally plus registers. It has a parameter N and ports for in_vld/xs/rem/root and out_vld/xs/rem/root. The top generates N instances.

## Test plan
- Reset: hold rst_n=0 with x_vld=1 toggling → y_vld stays 0. Release, drive nothing → y_vld stays 0 indefinitely.
- Corner operands, one per cycle, WIDTH=32:
  - 0→0, 1→1, 2→1, 3→1, 4→2
  - 15→3, 16→4
  - 0xFFFE0000→65534, 0xFFFE0001→65535, 0xFFFFFFFF→65535
  - Each result appears exactly 16 cycles after its input, in order.
- Full throughput: 1000 consecutive random operands with x_vld=1 → 1000 consecutive y_vld=1 cycles. Each y satisfies y² ≤ x < (y+1)².
- Bubbles: x_vld pattern 1,0,0,1,1,0,1 with x=100,–,–,81,82,–,1,000,000 → y_vld pattern identical, 16 cycles later, with y=10,9,9,1000. y holds its value through the gaps.
- Reset mid-flight: stream 8 operands, assert rst_n=0 for 1 cycle at cycle 5 → no y_vld for any of them. Operands issued after release complete normally with latency 16.
- Parameter sweep: WIDTH=8 exhaustive over 0..255 → latency 4 and y=floor(sqrt(x)) for every value.

Source files
------------

// File: rtl/isqrt_pkg.sv
// Shared helpers for the pipelined integer square root: latency query and
// operand-width legality check.
package isqrt_pkg;

  localparam int unsigned ISQRT_MIN_WIDTH = 2;

  // Cycles from an accepted operand to its result; one stage per root bit.
  function automatic int unsigned isqrt_latency(input int unsigned width);
    return width / 2;
  endfunction

  function automatic bit isqrt_width_ok(input int unsigned width);
    return (width >= ISQRT_MIN_WIDTH) && (width % 2 == 0);
  endfunction

endpackage

// File: rtl/isqrt_stage.sv
// One restoring square-root step: consumes the top two operand bits and
// produces one root bit. Data flops load only for valid tokens.
module isqrt_stage
  import isqrt_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [2*N-1:0]   in_xs,
  input  logic [N+1:0]     in_rem,
  input  logic [N-1:0]     in_root,
  output logic             out_vld,
  output logic [2*N-1:0]   out_xs,
  output logic [N+1:0]     out_rem,
  output logic [N-1:0]     out_root
);

  localparam int unsigned W = 2 * N;

  logic [N+1:0]   rem_sh;
  logic [N+1:0]   trial;
  logic           ge;
  logic [N+1:0]   rem_n;
  logic [N-1:0]   root_n;
  logic [W-1:0]   xs_n;

  always_comb begin
    rem_sh = (in_rem << 2) | {{N{1'b0}}, in_xs[W-1 -: 2]};
    trial  = {in_root, 2'b01};
    ge     = (rem_sh >= trial);
    rem_n  = ge ? (rem_sh - trial) : rem_sh;
    root_n = in_root << 1;
    root_n[0] = ge;
    xs_n   = in_xs << 2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
    end else begin
      out_vld <= in_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (in_vld) begin
      out_xs   <= xs_n;
      out_rem  <= rem_n;
      out_root <= root_n;
    end
  end

endmodule

// File: rtl/isqrt_pipe.sv
// Fully pipelined y = floor(sqrt(x)); one operand per cycle, results in
// order after WIDTH/2 cycles.
module isqrt_pipe
  import isqrt_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 x_vld,
  input  logic [WIDTH-1:0]     x,
  output logic                 y_vld,
  output logic [WIDTH/2-1:0]   y
);

  localparam int unsigned N = isqrt_latency(WIDTH);

  if (!isqrt_width_ok(WIDTH)) begin : g_bad_width
    $error("isqrt_pipe: WIDTH must be even and at least 2");
  end

  // Index k holds the inputs of stage k; index N is the final result.
  logic             vld  [N+1];
  logic [WIDTH-1:0] xs   [N+1];
  logic [N+1:0]     rem  [N+1];
  logic [N-1:0]     root [N+1];

  assign vld[0]  = x_vld;
  assign xs[0]   = x;
  assign rem[0]  = '0;
  assign root[0] = '0;

  for (genvar k = 0; k < N; k++) begin : g_stage
    isqrt_stage #(
      .N (N)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_vld   (vld[k]),
      .in_xs    (xs[k]),
      .in_rem   (rem[k]),
      .in_root  (root[k]),
      .out_vld  (vld[k+1]),
      .out_xs   (xs[k+1]),
      .out_rem  (rem[k+1]),
      .out_root (root[k+1])
    );
  end

  assign y_vld = vld[N];
  assign y     = root[N];

endmodule

// File: tb/tb_isqrt_pipe.sv
// Scoreboard bench for isqrt_pipe at WIDTH=32 and WIDTH=8.
module tb_isqrt_pipe;

  typedef struct {
    logic [31:0] x;
    logic [15:0] e;
    bit          has_e;
    int unsigned t;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        x_vld32 = 1'b0;
  logic [31:0] x32 = '0;
  logic        y_vld32;
  logic [15:0] y32;
  logic        x_vld8 = 1'b0;
  logic [7:0]  x8 = '0;
  logic        y_vld8;
  logic [3:0]  y8;

  int unsigned cyc = 0;
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  ent_t q32[$];
  ent_t q8[$];
  bit idle_chk = 1'b0;
  bit hold_chk = 1'b0;
  bit have_last = 1'b0;
  logic [15:0] last32 = '0;

  isqrt_pipe #(.WIDTH(32)) u_dut32 (
    .clk (clk), .rst_n (rst_n), .x_vld (x_vld32), .x (x32), .y_vld (y_vld32), .y (y32)
  );

  isqrt_pipe #(.WIDTH(8)) u_dut8 (
    .clk (clk), .rst_n (rst_n), .x_vld (x_vld8), .x (x8), .y_vld (y_vld8), .y (y8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok, input longint unsigned act,
                       input longint unsigned exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive32(input bit v, input logic [31:0] val, input bit has_e,
                         input logic [15:0] e, input bit push);
    ent_t en;
    @(negedge clk);
    x_vld32 = v;
    x32 = val;
    if (v && push) begin
      en.x = val; en.e = e; en.has_e = has_e; en.t = cyc;
      q32.push_back(en);
    end
  endtask

  task automatic drive8(input bit v, input logic [7:0] val);
    ent_t en;
    @(negedge clk);
    x_vld8 = v;
    x8 = val;
    if (v) begin
      en.x = {24'd0, val}; en.e = '0; en.has_e = 1'b0; en.t = cyc;
      q8.push_back(en);
    end
  endtask

  task automatic drain();
    int unsigned n = 0;
    while ((q32.size() != 0 || q8.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q32.size() != 0 || q8.size() != 0)
      check("drain_timeout", 1'b0, q32.size() + q8.size(), 0);
  endtask

  task automatic monitor();
    ent_t en;
    logic [63:0] yy;
    forever begin
      @(negedge clk);
      if (idle_chk) begin
        check("idle_vld32", !y_vld32, y_vld32, 0);
        check("idle_vld8", !y_vld8, y_vld8, 0);
      end
      if (y_vld32) begin
        if (q32.size() == 0) begin
          check("unexpected_vld32", 1'b0, 1, 0);
        end else begin
          en = q32.pop_front();
          check("latency32", (cyc - en.t) == 16, cyc - en.t, 16);
          if (en.has_e) begin
            check($sformatf("y32 x=%0d", en.x), y32 == en.e, y32, en.e);
            last32 = en.e;
            have_last = 1'b1;
          end else begin
            yy = {48'd0, y32};
            check($sformatf("bound32 x=%0d", en.x),
                  (yy * yy <= {32'd0, en.x}) && ((yy + 1) * (yy + 1) > {32'd0, en.x}),
                  y32, en.x);
          end
        end
      end else if (hold_chk && have_last) begin
        check("hold32", y32 == last32, y32, last32);
      end
      if (y_vld8) begin
        if (q8.size() == 0) begin
          check("unexpected_vld8", 1'b0, 1, 0);
        end else begin
          en = q8.pop_front();
          check("latency8", (cyc - en.t) == 4, cyc - en.t, 4);
          yy = {60'd0, y8};
          check($sformatf("bound8 x=%0d", en.x),
                (yy * yy <= {32'd0, en.x}) && ((yy + 1) * (yy + 1) > {32'd0, en.x}),
                y8, en.x);
        end
      end
    end
  endtask

  logic [31:0] cx [17] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd15, 32'd16,
                           32'hFFFE0000, 32'hFFFE0001, 32'hFFFFFFFF,
                           32'd49, 32'd50, 32'd63, 32'd64, 32'd65535, 32'd65536, 32'd99};
  logic [15:0] ce [17] = '{16'd0, 16'd1, 16'd1, 16'd1, 16'd2, 16'd3, 16'd4,
                           16'd65534, 16'd65535, 16'd65535,
                           16'd7, 16'd7, 16'd7, 16'd8, 16'd255, 16'd256, 16'd9};

  initial begin
    fork
      monitor();
    join_none

    // Reset held with x_vld toggling: nothing may come out.
    idle_chk = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive32(i[0], 32'd1000 + i, 1'b0, '0, 1'b0);
      @(negedge clk);
      x_vld8 = i[0];
      x8 = 8'(i);
    end
    @(negedge clk);
    rst_n = 1'b1;
    x_vld32 = 1'b0;
    x_vld8 = 1'b0;
    repeat (25) @(negedge clk);
    idle_chk = 1'b0;

    // Corner operands, back to back.
    for (int i = 0; i < 10; i++) drive32(1'b1, cx[i], 1'b1, ce[i], 1'b1);
    drive32(1'b0, '0, 1'b0, '0, 1'b0);
    drain();

    // Full throughput with random operands.
    for (int i = 0; i < 1000; i++) drive32(1'b1, $urandom, 1'b0, '0, 1'b1);
    drive32(1'b0, '0, 1'b0, '0, 1'b0);
    drain();

    // Bubbles reappear unchanged; y holds through the gaps.
    have_last = 1'b0;
    hold_chk = 1'b1;
    drive32(1'b1, 32'd100, 1'b1, 16'd10, 1'b1);
    drive32(1'b0, '0, 1'b0, '0, 1'b0);
    drive32(1'b0, '0, 1'b0, '0, 1'b0);
    drive32(1'b1, 32'd81, 1'b1, 16'd9, 1'b1);
    drive32(1'b1, 32'd82, 1'b1, 16'd9, 1'b1);
    drive32(1'b0, '0, 1'b0, '0, 1'b0);
    drive32(1'b1, 32'd1000000, 1'b1, 16'd1000, 1'b1);
    drive32(1'b0, '0, 1'b0, '0, 1'b0);
    drain();
    repeat (3) @(negedge clk);
    hold_chk = 1'b0;

    // Reset mid-flight discards everything in the pipe.
    for (int i = 0; i < 8; i++) drive32(1'b1, 32'd400 + i, 1'b0, '0, 1'b0);
    drive32(1'b0, '0, 1'b0, '0, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    idle_chk = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    idle_chk = 1'b0;
    for (int i = 10; i < 17; i++) drive32(1'b1, cx[i], 1'b1, ce[i], 1'b1);
    drive32(1'b0, '0, 1'b0, '0, 1'b0);
    drain();

    // WIDTH=8 exhaustive sweep.
    for (int i = 0; i < 256; i++) drive8(1'b1, 8'(i));
    drive8(1'b0, '0);
    drain();
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
